rvfi_commit_sequencer: RTL

// - Sits between the core's RVFI commit ports and a single-port trace sink (trace writer / encoder).
// - Each cycle, captures up to NrCommitPorts retired or trapped instructions, keeping program order
//   (port 0 first), and buffers them. It then drains them to the sink one per cycle over a valid/ready handshake.
// - Owns end-of-test sequencing: tohost detection, drain-before-finish, and timeout.

---
 rtl/rvfi_commit_sequencer_pkg.sv | 36 +++
 rtl/rvfi_commit_sequencer_if.sv | 13 +
 rtl/rvfi_commit_sequencer_mpush_fifo.sv | 63 ++++++
 rtl/rvfi_commit_sequencer.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/rvfi_commit_sequencer_pkg.sv
// Shared types and constants for the RVFI commit sequencer.
package rvfi_commit_sequencer_pkg;

   // Minimal core configuration: the fields this block consumes
   typedef struct packed {
      int unsigned NrCommitPorts;
      int unsigned XLEN;
      int unsigned PLEN;
   } cva6_cfg_t;

   localparam int unsigned RVFI_XLEN = 32;
   localparam int unsigned RVFI_PLEN = 34;

   localparam cva6_cfg_t cva6_cfg_empty = '{NrCommitPorts: 2, XLEN: RVFI_XLEN, PLEN: RVFI_PLEN};

   // Default per-port RVFI record
   typedef struct packed {
      logic                   valid;
      logic                   trap;
      logic [31:0]            insn;
      logic [RVFI_XLEN-1:0]   pc_rdata;
      logic [RVFI_PLEN-1:0]   mem_paddr;
      logic [RVFI_XLEN/8-1:0] mem_wmask;
      logic [RVFI_XLEN-1:0]   mem_wdata;
   } rvfi_rec_t;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      DRAIN = 2'd1,
      DONE  = 2'd2
   } seq_state_e;

   localparam logic [31:0] EOT_TIMEOUT = 32'hFFFF_FFFF;
   localparam int unsigned DROP_CNT_W  = 16;

endpackage

// File: rtl/rvfi_commit_sequencer_if.sv
// Single-port valid/ready trace sink link carrying one commit record plus its port index.
interface rvfi_commit_sequencer_if #(
   parameter type         rec_t  = logic,
   parameter int unsigned PORT_W = 1
);
   logic              valid;
   logic              ready;
   rec_t              instr;
   logic [PORT_W-1:0] port;

   modport master (output valid, output instr, output port, input ready);
   modport slave  (input valid, input instr, input port, output ready);
endinterface

// File: rtl/rvfi_commit_sequencer_mpush_fifo.sv
// Multi-push / single-pop FIFO; pushed entries are packed in ascending push index order.
module rvfi_commit_sequencer_mpush_fifo #(
   parameter int unsigned DEPTH   = 8,
   parameter int unsigned NPUSH   = 2,
   parameter type         entry_t = logic
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   flush,
   input  logic [NPUSH-1:0]       push,
   input  entry_t                 data [NPUSH],
   input  logic                   pop,
   output entry_t                 head,
   output logic [$clog2(DEPTH):0] count,
   output logic [$clog2(DEPTH):0] free
);
   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   entry_t             mem [DEPTH];
   logic [PTR_W-1:0]   wptr;
   logic [PTR_W-1:0]   rptr;
   logic [CNT_W-1:0]   rank [NPUSH];
   logic [CNT_W-1:0]   n_push;

   // Slot offset of each pushed entry relative to the write pointer
   always_comb begin
      n_push = '0;
      for (int unsigned p = 0; p < NPUSH; p++) begin
         rank[p] = n_push;
         n_push  = n_push + CNT_W'(push[p]);
      end
   end

   assign head = mem[rptr];
   assign free = (CNT_W'(DEPTH) - count) + CNT_W'(pop);

   // Storage, pointers and occupancy
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (flush) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         for (int unsigned p = 0; p < NPUSH; p++) begin
            if (push[p]) begin
               mem[PTR_W'(wptr + PTR_W'(rank[p]))] <= data[p];
            end
         end
         wptr  <= wptr + PTR_W'(n_push);
         rptr  <= rptr + PTR_W'(pop);
         count <= count + n_push - CNT_W'(pop);
      end
   end

endmodule

// File: rtl/rvfi_commit_sequencer.sv
// Serialises multi-port RVFI commits into a single trace stream and sequences end of test.
module rvfi_commit_sequencer
   import rvfi_commit_sequencer_pkg::*;
#(
   parameter cva6_cfg_t   CVA6Cfg      = cva6_cfg_empty,
   parameter type         rvfi_instr_t = rvfi_rec_t,
   parameter int unsigned DEPTH        = 8,
   parameter int unsigned TIMEOUT      = 2000000
) (
   input  logic                        clk_i,
   input  logic                        rst_ni,
   input  rvfi_instr_t                 rvfi_i [CVA6Cfg.NrCommitPorts],
   input  logic [CVA6Cfg.PLEN-1:0]     tohost_addr_i,
   rvfi_commit_sequencer_if.master     sink,
   output logic                        overflow_o,
   output logic [DROP_CNT_W-1:0]       drop_count_o,
   output logic [31:0]                 eot_o
);
   localparam int unsigned NPORTS  = CVA6Cfg.NrCommitPorts;
   localparam int unsigned PLEN    = CVA6Cfg.PLEN;
   localparam int unsigned PORT_W  = (NPORTS > 1) ? $clog2(NPORTS) : 1;
   localparam int unsigned CNT_W   = $clog2(DEPTH) + 1;
   localparam int unsigned NDROP_W = $clog2(NPORTS + 1);

   localparam logic [1:0] S_RUN   = RUN;
   localparam logic [1:0] S_DRAIN = DRAIN;
   localparam logic [1:0] S_DONE  = DONE;

   typedef struct packed {
      logic [PORT_W-1:0] port;
      rvfi_instr_t       rec;
   } entry_t;

   logic [1:0]           state;
   logic [1:0]           state_next;
   logic [31:0]          cycle_cnt;
   logic [31:0]          code_q;
   logic [NPORTS-1:0]    live;
   logic [NPORTS-1:0]    tohost_match;
   logic [NPORTS-1:0]    push;
   entry_t               fifo_in [NPORTS];
   entry_t               head;
   logic [CNT_W-1:0]     count;
   logic [CNT_W-1:0]     free;
   logic [CNT_W-1:0]     slots;
   logic [NDROP_W-1:0]   n_drop;
   logic [DROP_CNT_W:0]  drop_sum;
   logic                 hit;
   logic [31:0]          hit_code;
   logic                 pop;
   logic                 timeout_hit;
   logic                 flush;

   assign sink.valid  = (count != '0) && (state != S_DONE);
   assign sink.instr  = head.rec;
   assign sink.port   = head.port;
   assign pop         = sink.valid && sink.ready;
   assign timeout_hit = (cycle_cnt == 32'(TIMEOUT));
   assign flush       = (state != S_DONE) && (state_next == S_DONE);
   assign drop_sum    = {1'b0, drop_count_o} + (DROP_CNT_W + 1)'(n_drop);

   // Per-port liveness and tohost store detection
   always_comb begin
      for (int unsigned p = 0; p < NPORTS; p++) begin
         live[p]         = rvfi_i[p].valid | rvfi_i[p].trap;
         tohost_match[p] = (tohost_addr_i != '0) && (rvfi_i[p].mem_wmask != '0)
                           && (PLEN'(rvfi_i[p].mem_paddr) == tohost_addr_i)
                           && rvfi_i[p].mem_wdata[0];
      end
   end

   // Admit live entries in port order into free slots; a tohost hit cuts off higher ports
   always_comb begin
      push     = '0;
      n_drop   = '0;
      hit      = 1'b0;
      hit_code = '0;
      slots    = '0;
      for (int unsigned p = 0; p < NPORTS; p++) begin
         fifo_in[p].port = PORT_W'(p);
         fifo_in[p].rec  = rvfi_i[p];
         if ((state == S_RUN) && live[p] && !hit) begin
            if (slots < free) begin
               push[p] = 1'b1;
               slots   = slots + CNT_W'(1);
               if (tohost_match[p]) begin
                  hit      = 1'b1;
                  hit_code = rvfi_i[p].mem_wdata[31:0];
               end
            end else begin
               n_drop = n_drop + NDROP_W'(1);
            end
         end
      end
   end

   rvfi_commit_sequencer_mpush_fifo #(
      .DEPTH   (DEPTH),
      .NPUSH   (NPORTS),
      .entry_t (entry_t)
   ) u_fifo (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .flush  (flush),
      .push   (push),
      .data   (fifo_in),
      .pop    (pop),
      .head   (head),
      .count  (count),
      .free   (free)
   );

   // Next-state: timeout has priority over tohost hit and drain completion
   always_comb begin
      state_next = state;
      case (state)
         S_RUN: begin
            if (timeout_hit) begin
               state_next = S_DONE;
            end else if (hit) begin
               state_next = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (timeout_hit || (count == '0)) begin
               state_next = S_DONE;
            end
         end
         default: state_next = S_DONE;
      endcase
   end

   // State register
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state <= S_RUN;
      end else begin
         state <= state_next;
      end
   end

   // Cycle counter, captured tohost code and end-of-test code
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cycle_cnt <= '0;
         code_q    <= '0;
         eot_o     <= '0;
      end else begin
         if (state != S_DONE) begin
            cycle_cnt <= cycle_cnt + 32'd1;
         end
         if ((state == S_RUN) && hit) begin
            code_q <= hit_code;
         end
         if (flush) begin
            eot_o <= timeout_hit ? EOT_TIMEOUT : code_q;
         end
      end
   end

   // Sticky overflow flag and saturating drop counter
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         overflow_o   <= 1'b0;
         drop_count_o <= '0;
      end else if (n_drop != '0) begin
         overflow_o   <= 1'b1;
         drop_count_o <= drop_sum[DROP_CNT_W] ? '1 : drop_sum[DROP_CNT_W-1:0];
      end
   end

endmodule
